// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the GEMM tile sequencer.
//   - default tile shape, memory depth and width constants
//   - sequencer state enum
//   - tile-count / size-validation helpers
package gemm_pkg;

  localparam int unsigned DefInDataWidth   = 8;
  localparam int unsigned DefOutDataWidth  = 32;
  localparam int unsigned DefSizeAddrWidth = 8;
  localparam int unsigned DefDataDepth     = 256;
  localparam int unsigned DefM             = 8;
  localparam int unsigned DefK             = 4;
  localparam int unsigned DefN             = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    WRITE,
    DONE
  } state_e;

  // Number of tiles along a dimension whose tile size is 2**shift.
  function automatic logic [31:0] tile_count(input logic [31:0] size, input int unsigned shift);
    return size >> shift;
  endfunction

  // Non-zero and an exact multiple of 2**shift.
  function automatic logic size_ok(input logic [31:0] size, input int unsigned shift);
    logic [31:0] mask;
    mask = (32'd1 << shift) - 32'd1;
    return (size != '0) && ((size & mask) == '0);
  endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// gemm_tile_counter: nested kt (inner) / nt (middle) / mt (outer) tile counter.
//   clk_i, rst_ni      clock, async active-low reset
//   clr_i              return all indices to 0 (priority over inc_i)
//   inc_i              advance kt, carrying into nt then mt
//   *_cnt_i            tile counts per dimension (wrap bounds)
//   kt_o               current kt index
//   *_nxt_o            indices for the following cycle
//   *_wrap_o           index is at its last value
module gemm_tile_counter
  import gemm_pkg::*;
#(
  parameter int unsigned Width = DefSizeAddrWidth
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] kt_cnt_i,
  input  logic [Width-1:0] nt_cnt_i,
  input  logic [Width-1:0] mt_cnt_i,
  output logic [Width-1:0] kt_o,
  output logic [Width-1:0] kt_nxt_o,
  output logic [Width-1:0] nt_nxt_o,
  output logic [Width-1:0] mt_nxt_o,
  output logic             kt_wrap_o,
  output logic             nt_wrap_o,
  output logic             mt_wrap_o
);

  logic [Width-1:0] nt_q, mt_q;

  assign kt_wrap_o = (kt_o == kt_cnt_i - Width'(1));
  assign nt_wrap_o = (nt_q == nt_cnt_i - Width'(1));
  assign mt_wrap_o = (mt_q == mt_cnt_i - Width'(1));

  always_comb begin
    kt_nxt_o = kt_o;
    nt_nxt_o = nt_q;
    mt_nxt_o = mt_q;
    if (clr_i) begin
      kt_nxt_o = '0;
      nt_nxt_o = '0;
      mt_nxt_o = '0;
    end else if (inc_i) begin
      kt_nxt_o = kt_wrap_o ? '0 : kt_o + Width'(1);
      if (kt_wrap_o) begin
        nt_nxt_o = nt_wrap_o ? '0 : nt_q + Width'(1);
        if (nt_wrap_o) begin
          mt_nxt_o = mt_wrap_o ? '0 : mt_q + Width'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kt_o <= '0;
      nt_q <= '0;
      mt_q <= '0;
    end else begin
      kt_o <= kt_nxt_o;
      nt_q <= nt_nxt_o;
      mt_q <= mt_nxt_o;
    end
  end

endmodule

// File: rtl/gemm_tile_ctrl.sv
// gemm_tile_ctrl: tile sequencer for C = A*B (or C += A*B) over tile-packed SRAMs.
//   clk_i, rst_ni                 clock, async active-low reset
//   start_i, accum_i              job request / accumulate mode (sampled in IDLE)
//   M_size_i, K_size_i, N_size_i  matrix dimensions (latched with start)
//   sram_{a,b,c}_addr_o           SRAM word addresses (registered)
//   sram_c_we_o                   C write enable (WRITE state)
//   pe_valid_o, pe_first_o        A/B read data valid / first K-step of tile
//   pe_load_c_o                   first K-step also adds C read data (accum mode)
//   busy_o, done_o, err_o         job active / end pulse / rejected-start pulse
module gemm_tile_ctrl
  import gemm_pkg::*;
#(
  parameter int unsigned InDataWidth   = DefInDataWidth,
  parameter int unsigned OutDataWidth  = DefOutDataWidth,
  parameter int unsigned SizeAddrWidth = DefSizeAddrWidth,
  parameter int unsigned DataDepth     = DefDataDepth,
  parameter int unsigned AddrWidth     = $clog2(DataDepth),
  parameter int unsigned M             = DefM,
  parameter int unsigned K             = DefK,
  parameter int unsigned N             = DefN
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     accum_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] K_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  output logic [AddrWidth-1:0]     sram_a_addr_o,
  output logic [AddrWidth-1:0]     sram_b_addr_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic                     sram_c_we_o,
  output logic                     pe_valid_o,
  output logic                     pe_first_o,
  output logic                     pe_load_c_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam int unsigned SW     = SizeAddrWidth;
  localparam int unsigned ProdW  = 2 * SizeAddrWidth;
  localparam int unsigned MShift = $clog2(M);
  localparam int unsigned KShift = $clog2(K);
  localparam int unsigned NShift = $clog2(N);

  // Element widths belong to the datapath; the sequencer only carries them.
  if (OutDataWidth < InDataWidth) begin : g_width_note
  end

  state_e state_q, state_d;

  logic [SW-1:0]        mt_cnt_q, kt_cnt_q, nt_cnt_q;
  logic                 accum_q, last_q, err_q;
  logic                 pe_valid_q, pe_first_q, pe_load_c_q;
  logic [AddrWidth-1:0] a_addr_q, b_addr_q, c_addr_q, tile_c_q;

  logic [31:0]          mt_new, kt_new, nt_new;
  logic [63:0]          mk_prod, kn_prod, mn_prod;
  logic                 size_valid, start_ok, accum_nxt;

  logic [SW-1:0]        kt_q, kt_nxt, nt_nxt, mt_nxt;
  logic                 kt_wrap, nt_wrap, mt_wrap;
  logic [ProdW-1:0]     a_word, b_word, c_word;

  // Size validation on the live inputs; only meaningful in IDLE.
  always_comb begin
    mt_new     = tile_count(32'(M_size_i), MShift);
    kt_new     = tile_count(32'(K_size_i), KShift);
    nt_new     = tile_count(32'(N_size_i), NShift);
    mk_prod    = 64'(mt_new) * 64'(kt_new);
    kn_prod    = 64'(kt_new) * 64'(nt_new);
    mn_prod    = 64'(mt_new) * 64'(nt_new);
    size_valid = size_ok(32'(M_size_i), MShift) &&
                 size_ok(32'(K_size_i), KShift) &&
                 size_ok(32'(N_size_i), NShift) &&
                 (mk_prod <= 64'(DataDepth)) &&
                 (kn_prod <= 64'(DataDepth)) &&
                 (mn_prod <= 64'(DataDepth));
  end

  assign start_ok  = (state_q == IDLE) && start_i && size_valid;
  assign accum_nxt = (state_q == IDLE) ? accum_i : accum_q;

  gemm_tile_counter #(
    .Width(SW)
  ) u_counter (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (start_ok),
    .inc_i    (state_q == ISSUE),
    .kt_cnt_i (kt_cnt_q),
    .nt_cnt_i (nt_cnt_q),
    .mt_cnt_i (mt_cnt_q),
    .kt_o     (kt_q),
    .kt_nxt_o (kt_nxt),
    .nt_nxt_o (nt_nxt),
    .mt_nxt_o (mt_nxt),
    .kt_wrap_o(kt_wrap),
    .nt_wrap_o(nt_wrap),
    .mt_wrap_o(mt_wrap)
  );

  // Addresses are built from the counter's next-cycle indices so they can be
  // registered and still line up with the state they belong to. On the start
  // edge the indices are all zero, so the not-yet-latched counts do not matter.
  always_comb begin
    a_word = ProdW'(mt_nxt) * ProdW'(kt_cnt_q) + ProdW'(kt_nxt);
    b_word = ProdW'(kt_nxt) * ProdW'(nt_cnt_q) + ProdW'(nt_nxt);
    c_word = ProdW'(mt_nxt) * ProdW'(nt_cnt_q) + ProdW'(nt_nxt);
  end

  always_comb begin
    state_d     = state_q;
    sram_c_we_o = 1'b0;
    done_o      = 1'b0;
    busy_o      = (state_q != IDLE);
    unique case (state_q)
      IDLE:    if (start_ok) state_d = ISSUE;
      ISSUE:   if (kt_wrap) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE: begin
        sram_c_we_o = 1'b1;
        state_d     = last_q ? DONE : ISSUE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      mt_cnt_q    <= '0;
      kt_cnt_q    <= '0;
      nt_cnt_q    <= '0;
      accum_q     <= 1'b0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      pe_valid_q  <= 1'b0;
      pe_first_q  <= 1'b0;
      pe_load_c_q <= 1'b0;
      tile_c_q    <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      c_addr_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && start_i && !size_valid;

      if (start_ok) begin
        mt_cnt_q <= SW'(mt_new);
        kt_cnt_q <= SW'(kt_new);
        nt_cnt_q <= SW'(nt_new);
        accum_q  <= accum_i;
      end

      // Last tile is known once its final K-step has been issued.
      if (start_ok) begin
        last_q <= 1'b0;
      end else if ((state_q == ISSUE) && kt_wrap && nt_wrap && mt_wrap) begin
        last_q <= 1'b1;
      end

      pe_valid_q  <= (state_q == ISSUE);
      pe_first_q  <= (state_q == ISSUE) && (kt_q == '0);
      pe_load_c_q <= (state_q == ISSUE) && (kt_q == '0) && accum_q;

      // The counter has moved on to the next tile by WRITE; keep this one's C word.
      if ((state_d == ISSUE) && (kt_nxt == '0)) begin
        tile_c_q <= AddrWidth'(c_word);
      end

      a_addr_q <= (state_d == ISSUE) ? AddrWidth'(a_word) : '0;
      b_addr_q <= (state_d == ISSUE) ? AddrWidth'(b_word) : '0;
      if ((state_d == ISSUE) && (kt_nxt == '0) && accum_nxt) begin
        c_addr_q <= AddrWidth'(c_word);
      end else if (state_d == WRITE) begin
        c_addr_q <= tile_c_q;
      end else begin
        c_addr_q <= '0;
      end
    end
  end

  assign sram_a_addr_o = a_addr_q;
  assign sram_b_addr_o = b_addr_q;
  assign sram_c_addr_o = c_addr_q;
  assign pe_valid_o    = pe_valid_q;
  assign pe_first_o    = pe_first_q;
  assign pe_load_c_o   = pe_load_c_q;
  assign err_o         = err_q;

endmodule
